// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-read-port register file.
package regfile_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } rf_state_e;

  localparam int RF_WIDTH = 32;
  localparam int RF_DEPTH = 32;
  localparam int RF_NRD   = 2;

  // Address width for a given depth; never narrower than one bit.
  function automatic int rf_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One registered read port: read mux, zero-register mask, optional write bypass.
// Optional feature: define REGFILE_BYPASS_EN for same-edge write-through forwarding.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int ZERO_REG = 1,
  parameter int AW       = rf_aw(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_mem [DEPTH],
  input  logic             i_wr_vld,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] w_sel;
  logic [WIDTH-1:0] w_nxt;
  logic [WIDTH-1:0] r_data;

  always_comb begin
    w_sel = i_mem[i_addr];
`ifdef REGFILE_BYPASS_EN
    if (i_wr_vld && (i_wr_addr == i_addr)) w_sel = i_wr_data;
`endif
    w_nxt = w_sel;
    if ((ZERO_REG != 0) && (i_addr == '0)) w_nxt = '0;
    // Outside normal reads (clearing, or the clear_req edge) the port loads zero.
    if (!i_rd_en) w_nxt = '0;
  end

`ifndef REGFILE_BYPASS_EN
  logic w_unused;
  assign w_unused = ^{i_wr_vld, i_wr_addr, i_wr_data};
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_data <= '0;
    else       r_data <= w_nxt;
  end

  assign o_data = r_data;

endmodule

// File: rtl/regfile_mp.sv
// Register file with NRD registered read ports, one write port and a clear sequencer.
// Optional feature: define REGFILE_BYPASS_EN for same-edge write-through forwarding.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int WIDTH    = RF_WIDTH,
  parameter  int DEPTH    = RF_DEPTH,
  parameter  int NRD      = RF_NRD,
  parameter  int ZERO_REG = 1,
  localparam int AW       = rf_aw(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_req,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*WIDTH-1:0] rd_data,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  output logic                 ready
);

  rf_state_e        r_state, w_state_nxt;
  logic [AW-1:0]    r_idx, w_idx_nxt;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_mem_we;
  logic [AW-1:0]    w_mem_addr;
  logic [WIDTH-1:0] w_mem_wdata;
  logic             w_wr_ok;
  logic             w_rd_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_CLEAR;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_mem_we    = 1'b0;
    w_mem_addr  = wr_addr;
    w_mem_wdata = wr_data;
    w_wr_ok     = 1'b0;
    w_rd_en     = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        // Sweep one entry per edge; external writes and clear_req are ignored.
        w_mem_we    = 1'b1;
        w_mem_addr  = r_idx;
        w_mem_wdata = '0;
        w_idx_nxt   = r_idx + AW'(1);
        if (r_idx == AW'(DEPTH - 1)) w_state_nxt = ST_READY;
      end
      ST_READY: begin
        if (clear_req) begin
          w_state_nxt = ST_CLEAR;
          w_idx_nxt   = '0;
        end else begin
          w_rd_en  = 1'b1;
          w_wr_ok  = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
          w_mem_we = w_wr_ok;
        end
      end
      default: w_state_nxt = ST_CLEAR;
    endcase
  end

  assign ready = (r_state == ST_READY);

  // Storage is never reset directly; the clear sequencer zeroes it after reset.
  always_ff @(posedge clk) begin
    if (w_mem_we && !rst) r_mem[w_mem_addr] <= w_mem_wdata;
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    regfile_rdport #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .ZERO_REG(ZERO_REG),
      .AW      (AW)
    ) u_rdport (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_rd_en  (w_rd_en),
      .i_addr   (rd_addr[k*AW +: AW]),
      .i_mem    (r_mem),
      .i_wr_vld (w_wr_ok),
      .i_wr_addr(wr_addr),
      .i_wr_data(wr_data),
      .o_data   (rd_data[k*WIDTH +: WIDTH])
    );
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file, the next generation of the CPU's 32×32 register file. It provides NRD independently addressed, registered read ports and one write port. Every write commits, including writes whose address matches a read address. An optional hard-wired zero register and a hardware clear sequencer are built in, so the datapath can rely on a known-zero register state after reset or on request.

## Interface
- WIDTH, 32, data width in bits
- DEPTH, 32, number of registers (power of two, ≥2)
- NRD, 2, number of read ports (1–4)
- ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes
- AW, derived = $clog2(DEPTH), address width (localparam)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- clear_req  in  1  synchronous request to re-zero all registers
- rd_addr  in  NRD*AW  read addresses; port k occupies bits [k*AW +: AW]
- rd_data  out  NRD*WIDTH  registered read data; port k occupies bits [k*WIDTH +: WIDTH]
- wr_en  in  1  write strobe
- wr_addr  in  AW  write address
- wr_data  in  WIDTH  write data
- ready  out  1  1 = clearing complete, writes accepted

## Operation
- Two-state FSM: CLEAR, READY. A clear index idx (AW bits) is kept alongside the state.
- rst asserted: state=CLEAR, idx=0, ready=0, all rd_data=0. Array contents are not reset directly.
- CLEAR, each clk edge:
  - write 0 to mem[idx], then idx++.
  - On the edge that clears idx=DEPTH-1: state→READY, ready→1.
  - wr_en is ignored. clear_req is ignored and does not restart the sequence.
  - rd_data is loaded with 0 on every port.
- READY, each clk edge:
  - If clear_req: state→CLEAR, idx=0, ready→0. A write in the same cycle is dropped, and rd_data is loaded with 0.
  - Otherwise, if wr_en: mem[wr_addr] ← wr_data. This happens even when wr_addr equals any rd_addr.
  - ZERO_REG=1 and wr_addr=0: the write is discarded.
  - Each port k: rd_data[k] ← mem[rd_addr[k]] (pre-write value, or bypassed value; see Configuration).
  - ZERO_REG=1 and rd_addr[k]=0: rd_data[k] ← 0.
- Multiple ports may read the same address in the same cycle, and all receive identical data.

## Timing
- Read latency: 1 cycle. Address sampled at edge N; data valid after edge N and held until edge N+1.
- Write visible to a read whose address is sampled at edge N+1 or later (without bypass).
- Clear duration: exactly DEPTH edges after rst deassertion, or after the edge that samples clear_req. ready rises after the DEPTH-th edge.
- rst asserted mid-clear or mid-operation:
  - outputs go to 0 immediately (ready=0, rd_data=0);
  - the sequence restarts at idx=0 on the first edge after deassertion.
- Reset values: ready=0, rd_data=0 (all ports), state=CLEAR, idx=0.

## Configuration
- REGFILE_BYPASS_EN defined:
  - In READY, when wr_en=1 and wr_addr==rd_addr[k] (and the write is not discarded by ZERO_REG), rd_data[k] ← wr_data at the same edge.
  - This gives write-through forwarding with zero-cycle read-after-write.
- Undefined: rd_data[k] returns the old mem content at that edge. The new value appears on the next read.
- Either way, the write itself always commits.

## Structure
- Package regfile_pkg:
  - FSM state typedef (CLEAR, READY);
  - default WIDTH/DEPTH/NRD constants;
  - localparam helper for AW.
- Sub-module regfile_rdport, generated NRD times. It holds:
  - one read mux;
  - the zero-register mask;
  - the optional bypass compare;
  - the rd_data output register with async reset.
- The top level holds the storage array, write logic and clear FSM.

## Test plan
- Reset release, default params: ready=0 for 32 cycles, then 1. Reading regs 0–31 on both ports returns 0.
- In READY, write 0xDEADBEEF to r5, then read r5 on port 0 one cycle later. Port 0 returns 0xDEADBEEF; port 1 reading r6 returns 0.
- Same-cycle write r7=0x12345678 with rd_addr port0=7:
  - with REGFILE_BYPASS_EN: 0x12345678 after that edge;
  - without: old value 0, then 0x12345678 on the next read.
- ZERO_REG=1, write r0=0xFFFFFFFF, then read r0 on both ports: both return 0. With ZERO_REG=0 the same sequence returns 0xFFFFFFFF.
- Load r1..r3 with nonzero values, then pulse clear_req together with wr_en (r4=0xAA):
  - ready drops for 32 cycles;
  - wr_en pulses during the clear are ignored;
  - afterwards r1..r4 all read 0.
- Assert rst at idx=10 mid-clear: rd_data and ready go to 0 immediately. After release, ready rises after exactly 32 edges.
